// File: rtl/ratfl_chkpt_ctrl.sv
// Branch checkpoint buffer for RAT and free-list state.
// Restores the rename snapshot of a mispredicted branch.
module ratfl_chkpt_ctrl #(
   parameter int NCHKPT = 4,
   parameter int TAG_W  = 4,
   parameter int PREGS  = 128,
   parameter int PREG_W = 7,
   parameter int CNT_W  = $clog2(PREGS) + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      chkpt_we_i,
   input  logic [TAG_W-1:0]          chkpt_tag_i,
   input  logic [32*PREG_W-1:0]      chkpt_rat_map_i,
   input  logic [PREG_W-1:0]         chkpt_fl_head_i,
   input  logic [PREG_W-1:0]         chkpt_fl_tail_i,
   input  logic [CNT_W-1:0]          chkpt_fl_free_count_i,
   output logic                      chkpt_full_o,
   output logic [$clog2(NCHKPT):0]   chkpt_count_o,
   output logic                      chkpt_overflow_o,
   input  logic                      resolve_valid_i,
   input  logic [TAG_W-1:0]          resolve_tag_i,
   input  logic                      resolve_mispredict_i,
   output logic                      rat_recover_o,
   output logic [32*PREG_W-1:0]      rat_recover_map_o,
   output logic                      fl_recover_o,
   output logic [PREG_W-1:0]         fl_recover_head_o,
   output logic [PREG_W-1:0]         fl_recover_tail_o,
   output logic [CNT_W-1:0]          fl_recover_free_count_o
);

   localparam int IW = $clog2(NCHKPT);
   localparam int NW = IW + 1;
   localparam int MW = 32 * PREG_W;

   logic [NCHKPT-1:0] valid_q;
   logic [NCHKPT-1:0] done_q;
   logic [TAG_W-1:0]  tag_q [NCHKPT];
   logic [MW-1:0]     map_q [NCHKPT];
   logic [PREG_W-1:0] flh_q [NCHKPT];
   logic [PREG_W-1:0] flt_q [NCHKPT];
   logic [CNT_W-1:0]  flc_q [NCHKPT];
   logic [IW-1:0]     head_q;
   logic [IW-1:0]     tail_q;
   logic [NW-1:0]     count_q;
   logic              ovf_q;

   logic              hit;
   logic [IW-1:0]     m_idx;
   logic [IW-1:0]     m_off;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     off;
   logic              misp;
   logic              fix;
   logic              retire;
   logic              wr;
   logic [NCHKPT-1:0] kill;

   assign chkpt_full_o     = (count_q == NW'(NCHKPT));
   assign chkpt_count_o    = count_q;
   assign chkpt_overflow_o = ovf_q;

   // Scan youngest to oldest so the oldest match is the one left standing.
   always_comb begin
      hit   = 1'b0;
      m_idx = '0;
      m_off = '0;
      idx   = '0;
      for (int k = NCHKPT - 1; k >= 0; k--) begin
         idx = head_q + IW'(k);
         if (valid_q[idx] && tag_q[idx] == resolve_tag_i) begin
            hit   = 1'b1;
            m_idx = idx;
            m_off = IW'(k);
         end
      end
   end

   assign misp   = resolve_valid_i & resolve_mispredict_i & hit;
   assign fix    = resolve_valid_i & ~resolve_mispredict_i & hit;
   assign retire = valid_q[head_q] & done_q[head_q]
                 & ~(misp & (m_off == '0));
   assign wr     = chkpt_we_i & ~chkpt_full_o & ~misp & ~rat_recover_o;

   always_comb begin
      kill = '0;
      off  = '0;
      for (int i = 0; i < NCHKPT; i++) begin
         off     = IW'(i) - head_q;
         kill[i] = misp && (off >= m_off);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q                 <= '0;
         done_q                  <= '0;
         head_q                  <= '0;
         tail_q                  <= '0;
         count_q                 <= '0;
         ovf_q                   <= 1'b0;
         rat_recover_o           <= 1'b0;
         fl_recover_o            <= 1'b0;
         rat_recover_map_o       <= '0;
         fl_recover_head_o       <= '0;
         fl_recover_tail_o       <= '0;
         fl_recover_free_count_o <= '0;
      end else begin
         if (chkpt_we_i && chkpt_full_o) ovf_q <= 1'b1;
         rat_recover_o <= misp;
         fl_recover_o  <= misp;
         if (misp) begin
            rat_recover_map_o       <= map_q[m_idx];
            fl_recover_head_o       <= flh_q[m_idx];
            fl_recover_tail_o       <= flt_q[m_idx];
            fl_recover_free_count_o <= flc_q[m_idx];
         end
         for (int i = 0; i < NCHKPT; i++) begin
            if (kill[i]) begin
               valid_q[i] <= 1'b0;
               done_q[i]  <= 1'b0;
            end
         end
         if (fix) done_q[m_idx] <= 1'b1;
         if (retire) begin
            valid_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + IW'(1);
         end
         if (wr) begin
            valid_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + IW'(1);
         end
         // Slots older than the mispredicted one survive, less any retiring head.
         if (misp) begin
            tail_q  <= m_idx;
            count_q <= NW'(m_off) - NW'(retire);
         end else begin
            count_q <= count_q + NW'(wr) - NW'(retire);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr) begin
         tag_q[tail_q] <= chkpt_tag_i;
         map_q[tail_q] <= chkpt_rat_map_i;
         flh_q[tail_q] <= chkpt_fl_head_i;
         flt_q[tail_q] <= chkpt_fl_tail_i;
         flc_q[tail_q] <= chkpt_fl_free_count_i;
      end
   end

endmodule
